uart_frame_tx: RTL and testbench

- Transmit-side framer for the UART link; the counterpart of the receive path that rebuilds messages from UART bytes.
- Accepts 16-bit payload words from the board logic and buffers each whole message.
- Sends every completed message as a byte stream on the AXI-stream input of the uart core: SOF, LEN, payload, parity.
- Sits between the word producers and the uart core's input_axis_* port.

---
 rtl/uart_frame_tx_pkg.sv | 27 ++
 rtl/uart_frame_tx_word_fifo.sv | 46 ++++
 rtl/uart_frame_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_tx_pkg
// Brief  : Shared constants, FSM encoding and parity helper for uart_frame_tx.
// Rev    : 1.0
// ============================================================================
package uart_frame_tx_pkg;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
  localparam int         MAX_LEN_DEFAULT  = 255;
  localparam int         DESC_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_LEN    = 3'd2,
    ST_PAY_HI = 3'd3,
    ST_PAY_LO = 3'd4,
    ST_PAR    = 3'd5
  } tx_state_t;

  function automatic logic [7:0] word_parity(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : (w[15:8] ^ w[7:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_tx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : word_fifo
// Brief  : Show-ahead synchronous FIFO; q is the head word whenever !empty.
// Rev    : 1.0
// ============================================================================
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Flush is done through the pointers; the array itself needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign q     = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_frame_tx
// Brief  : Buffers 16-bit payload messages and emits SOF/LEN/payload/parity frames.
// Rev    : 1.0
// ============================================================================
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 128,
  parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEFAULT,
  parameter int         MAX_LEN    = MAX_LEN_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic        ENA,
  input  logic        LAST,
  input  logic        LAST_AND_ODD,
  output logic        IN_READY,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        BUSY,
  output logic        OVERFLOW
);
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  tx_state_t state, state_nxt;
  logic [7:0] rem, rem_nxt;

  logic        out_of_reset;
  logic [8:0]  asm_len;
  logic [7:0]  asm_par;
  logic        overflow_q;

  logic [DESC_W-1:0] desc0, desc1;
  logic [1:0]        desc_count;

  logic [15:0] fifo_q;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        desc_pop;

  logic        accept, is_odd, is_last, too_long, word_ok, desc_push;
  logic [8:0]  inc, sum_len, close_len;
  logic [7:0]  word_par, close_par;
  logic [DESC_W-1:0] desc_new;

  assign IN_READY  = out_of_reset && !fifo_full && (desc_count != 2'd2);
  assign accept    = ENA && IN_READY;
  assign is_odd    = LAST_AND_ODD;
  assign is_last   = LAST || LAST_AND_ODD;
  assign inc       = is_odd ? 9'd1 : 9'd2;
  assign sum_len   = asm_len + inc;
  assign too_long  = (sum_len > MAX_LEN_W);
  assign word_ok   = accept && !too_long;
  assign word_par  = word_parity(DATA, is_odd);
  // A dropped last word still closes the message at the length gathered so far.
  assign close_len = word_ok ? sum_len : asm_len;
  assign close_par = word_ok ? (asm_par ^ word_par) : asm_par;
  assign desc_push = accept && is_last && (close_len != 9'd0);
  assign desc_new  = {close_len[7:0], close_par};

  assign OVERFLOW  = overflow_q;

  word_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_word_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (word_ok),
    .din   (DATA),
    .pop   (fifo_pop),
    .q     (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_of_reset <= 1'b0;
      asm_len      <= '0;
      asm_par      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (accept) begin
        if (is_last) begin
          asm_len <= '0;
          asm_par <= '0;
        end else if (word_ok) begin
          asm_len <= sum_len;
          asm_par <= asm_par ^ word_par;
        end
      end
      if ((ENA && !IN_READY) || (accept && too_long)) overflow_q <= 1'b1;
    end
  end

  // Two-entry descriptor queue; desc0 is the head used by the transmitter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      desc0      <= '0;
      desc1      <= '0;
      desc_count <= 2'd0;
    end else begin
      case ({desc_push, desc_pop})
        2'b10: begin
          if (desc_count == 2'd0) desc0 <= desc_new;
          else                    desc1 <= desc_new;
          desc_count <= desc_count + 2'd1;
        end
        2'b01: begin
          desc0      <= desc1;
          desc_count <= desc_count - 2'd1;
        end
        2'b11: begin
          desc0 <= (desc_count == 2'd1) ? desc_new : desc1;
          desc1 <= desc_new;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    fifo_pop  = 1'b0;
    desc_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (desc_count != 2'd0) begin
          state_nxt = ST_SOF;
          rem_nxt   = desc0[15:8];
        end
      end
      ST_SOF: begin
        tx_valid = 1'b1;
        tx_data  = SOF_BYTE;
        if (tx_ready) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        tx_valid = 1'b1;
        tx_data  = desc0[15:8];
        if (tx_ready) state_nxt = ST_PAY_HI;
      end
      ST_PAY_HI: begin
        tx_valid = 1'b1;
        tx_data  = fifo_q[15:8];
        if (tx_ready) begin
          if (rem == 8'd1) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_PAR;
          end else begin
            state_nxt = ST_PAY_LO;
          end
        end
      end
      ST_PAY_LO: begin
        tx_valid = 1'b1;
        tx_data  = fifo_q[7:0];
        if (tx_ready) begin
          fifo_pop  = 1'b1;
          rem_nxt   = rem - 8'd2;
          state_nxt = (rem == 8'd2) ? ST_PAR : ST_PAY_HI;
        end
      end
      ST_PAR: begin
        tx_valid = 1'b1;
        tx_data  = desc0[7:0];
        if (tx_ready) begin
          desc_pop  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_frame_tx
// Brief  : Self-checking bench for uart_frame_tx with a byte scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_uart_frame_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] DATA = 16'h0000;
  logic        ENA = 1'b0;
  logic        LAST = 1'b0;
  logic        LAST_AND_ODD = 1'b0;
  logic        IN_READY;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        BUSY;
  logic        OVERFLOW;

  uart_frame_tx dut (
    .CLK          (CLK),
    .RST          (RST),
    .DATA         (DATA),
    .ENA          (ENA),
    .LAST         (LAST),
    .LAST_AND_ODD (LAST_AND_ODD),
    .IN_READY     (IN_READY),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .BUSY         (BUSY),
    .OVERFLOW     (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          nw;
    logic        odd;
    int          nb;
    logic [63:0] exp;
  } frame_vec_t;

  frame_vec_t vecs[3];

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [7:0] exp_q[$];

  logic ready_mode  = 1'b0;
  logic ready_level = 1'b0;
  int   phase = 0;

  int         m_len = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] m_bytes[$];

  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_word(input logic [15:0] d, input logic l, input logic o, input logic rdy);
    int inc;
    logic [7:0] par;
    inc = o ? 1 : 2;
    if (!rdy) begin
      m_ovf = 1'b1;
    end else begin
      if (m_len + inc <= 255) begin
        m_bytes.push_back(d[15:8]);
        if (!o) m_bytes.push_back(d[7:0]);
        m_len += inc;
      end else begin
        m_ovf = 1'b1;
      end
      if (l || o) begin
        if (m_len != 0) begin
          par = 8'h00;
          exp_q.push_back(8'hA5);
          exp_q.push_back(8'(m_len));
          foreach (m_bytes[k]) begin
            exp_q.push_back(m_bytes[k]);
            par ^= m_bytes[k];
          end
          exp_q.push_back(par);
        end
        m_bytes.delete();
        m_len = 0;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic l, input logic o,
                           input logic exp_rdy, input logic use_model);
    check1("in_ready", IN_READY, exp_rdy);
    DATA = d;
    LAST = l;
    LAST_AND_ODD = o;
    ENA = 1'b1;
    if (use_model) model_word(d, l, o, exp_rdy);
    @(posedge CLK);
    #1;
    ENA = 1'b0;
    LAST = 1'b0;
    LAST_AND_ODD = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || tx_valid) begin
      errors++;
      $display("FAIL drain: %0d bytes still expected, tx_valid=%b", exp_q.size(), tx_valid);
    end
  endtask

  task automatic apply_vec(input int i);
    logic [63:0] e;
    logic [15:0] w;
    logic        fin;
    e = vecs[i].exp;
    for (int b = 0; b < vecs[i].nb; b++) exp_q.push_back(e[63 - 8*b -: 8]);
    for (int k = 0; k < vecs[i].nw; k++) begin
      w   = (k == 0) ? vecs[i].w0 : vecs[i].w1;
      fin = (k == vecs[i].nw - 1);
      send_word(w, fin && !vecs[i].odd, fin && vecs[i].odd, 1'b1, 1'b0);
    end
    @(negedge CLK);
    check1("latency_c1_idle", tx_valid, 1'b0);
    @(negedge CLK);
    check1("latency_c2_valid", tx_valid, 1'b1);
    wait_drain(200);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 2, 1'b0, 7, 64'hA504_1234_5678_0800};
    vecs[1] = '{16'hAB00, 16'h0000, 1, 1'b1, 4, 64'hA501_ABAB_0000_0000};
    vecs[2] = '{16'hC33C, 16'h0000, 1, 1'b0, 5, 64'hA502_C33C_FF00_0000};

    fork
      forever begin
        @(posedge CLK);
        #1;
        if (ready_mode) begin
          tx_ready = (phase == 2);
          phase = (phase == 2) ? 0 : phase + 1;
        end else begin
          tx_ready = ready_level;
        end
      end
      forever begin
        @(negedge CLK);
        if (!RST) begin
          stall_prev = 1'b0;
        end else begin
          if (stall_prev) begin
            checks++;
            if (!tx_valid || tx_data !== prev_data) begin
              errors++;
              $display("FAIL hold: valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, prev_data);
            end
          end
          checks++;
          if (BUSY !== tx_valid) begin
            errors++;
            $display("FAIL busy: BUSY=%b expected %b", BUSY, tx_valid);
          end
          if (tx_valid && tx_ready) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL byte: unexpected byte %h", tx_data);
            end else if (tx_data !== exp_q[0]) begin
              errors++;
              $display("FAIL byte: got %h expected %h", tx_data, exp_q.pop_front());
            end else begin
              void'(exp_q.pop_front());
            end
          end
          stall_prev = tx_valid && !tx_ready;
          prev_data  = tx_data;
        end
      end
      begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    #12;
    check1("rst_tx_valid", tx_valid, 1'b0);
    check1("rst_busy", BUSY, 1'b0);
    check1("rst_overflow", OVERFLOW, 1'b0);
    check1("rst_in_ready", IN_READY, 1'b0);
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx_data: got %h expected 00", tx_data);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Straight frame, odd frame, then the straight frame with a stalling sink.
    ready_level = 1'b1;
    apply_vec(0);
    apply_vec(1);
    ready_mode = 1'b1;
    apply_vec(0);
    ready_mode = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Two complete messages fill the descriptor queue while the sink stalls.
    ready_level = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    send_word(16'h1111, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word(16'h2233, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word(16'h4455, 1'b1, 1'b0, 1'b0, 1'b1);
    check1("overflow_after_drop", OVERFLOW, m_ovf);
    check1("overflow_is_set", OVERFLOW, 1'b1);
    ready_level = 1'b1;
    wait_drain(200);

    // Reset while the transmitter sits in PAY_LO.
    ready_level = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    send_word(16'h1234, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(16'h5678, 1'b1, 1'b0, 1'b1, 1'b1);
    begin
      int target, n;
      target = hs_count + 3;
      n = 0;
      ready_level = 1'b1;
      while (hs_count < target && n < 100) begin
        @(posedge CLK);
        n++;
      end
      ready_level = 1'b0;
      checks++;
      if (hs_count < target) begin
        errors++;
        $display("FAIL reach_pay_lo: got %0d handshakes expected %0d", hs_count, target);
      end
    end
    @(negedge CLK);
    checks++;
    if (!tx_valid || tx_data !== 8'h34) begin
      errors++;
      $display("FAIL pay_lo_byte: valid=%b data=%h expected valid=1 data=34", tx_valid, tx_data);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    exp_q.delete();
    m_bytes.delete();
    m_len = 0;
    m_ovf = 1'b0;
    #1;
    check1("midrst_tx_valid", tx_valid, 1'b0);
    check1("midrst_busy", BUSY, 1'b0);
    check1("midrst_overflow", OVERFLOW, 1'b0);
    check1("midrst_in_ready", IN_READY, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    ready_level = 1'b1;
    apply_vec(2);

    // 128 words: the last one would exceed 255 bytes and is dropped.
    begin
      logic [7:0] b;
      for (int i = 0; i < 128; i++) begin
        b = 8'(i);
        if (i == 127) check1("overflow_before_long", OVERFLOW, 1'b0);
        send_word({b, ~b}, (i == 127), 1'b0, 1'b1, 1'b1);
      end
    end
    check1("overflow_long", OVERFLOW, 1'b1);
    wait_drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
